mdio_master: RTL

//  Parametrised MDIO (IEEE 802.3 cl.22/cl.45) station-management master for PHY config/status.

---
 rtl/mdio_master.sv | 115 +++++++++++
 1 files changed

// File: rtl/mdio_master.sv
// mdio_master: clause-22/45 MDIO station-management master with split pad pins.
// Frames are built once at accept into a shift register; a per-bit divider paces MDC.
module mdio_master #(
  parameter int CLK_DIV      = 4,
  parameter int PREAMBLE_LEN = 32,
  parameter int SUPPORT_C45  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        c45,
  input  logic [1:0]  op,
  input  logic [4:0]  phyad,
  input  logic [4:0]  regad,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA} state_t;
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] LAST = DW'(2 * CLK_DIV - 1);
  localparam state_t FIRST = (PREAMBLE_LEN > 0) ? PRE : HDR;
  state_t        state_q, state_d;
  logic [4:0]    bit_q, last_bit;
  logic [DW-1:0] div_q;
  logic [31:0]   sh_q, sh_d, frame;
  logic [15:0]   rsh_q, rdata_q;
  logic          rd_q, c45_e, bad_op, rd_op, oe_d;
  logic          busy_q, ack_q, err_q, mdc_q, mdio_o_q, mdio_oe_q;
  assign c45_e    = (SUPPORT_C45 != 0) && c45;
  assign bad_op   = !c45_e && (op == 2'b00 || op == 2'b11);
  assign rd_op    = c45_e ? op[1] : (op == 2'b10);
  assign frame    = {1'b0, !c45_e, op, phyad, regad, 2'b10, wdata};
  assign last_bit = state_q == PRE ? 5'(PREAMBLE_LEN - 1) :
                    state_q == HDR ? 5'd13 : state_q == TA ? 5'd1 : 5'd15;
  assign state_d  = bit_q != last_bit ? state_q :
                    state_q == PRE ? HDR : state_q == HDR ? TA :
                    state_q == TA  ? DATA : IDLE;
  // Preamble bits come from a constant, so the frame word only advances outside PRE.
  assign sh_d     = state_q == PRE ? sh_q : {sh_q[30:0], 1'b0};
  assign oe_d     = state_d == PRE || state_d == HDR || !rd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      div_q     <= '0;
      sh_q      <= '0;
      rsh_q     <= '0;
      rdata_q   <= '0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      mdc_q     <= 1'b0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (!busy_q) begin
        if (req) begin
          err_q <= bad_op;
          ack_q <= bad_op;
          if (!bad_op) begin
            busy_q    <= 1'b1;
            state_q   <= FIRST;
            bit_q     <= '0;
            div_q     <= '0;
            sh_q      <= frame;
            rd_q      <= rd_op;
            mdio_o_q  <= (PREAMBLE_LEN > 0) ? 1'b1 : frame[31];
            mdio_oe_q <= 1'b1;
            mdc_q     <= 1'b0;
          end
        end
      end else if (div_q == HALF) begin
        mdc_q <= 1'b1;
        div_q <= div_q + 1'b1;
        if (rd_q && state_q == TA && bit_q == 5'd1) err_q <= mdio_i;
        if (rd_q && state_q == DATA) rsh_q <= {rsh_q[14:0], mdio_i};
      end else if (div_q == LAST) begin
        div_q   <= '0;
        mdc_q   <= 1'b0;
        sh_q    <= sh_d;
        state_q <= state_d;
        bit_q   <= state_d != state_q ? 5'd0 : bit_q + 5'd1;
        if (state_d == IDLE) begin
          busy_q    <= 1'b0;
          ack_q     <= 1'b1;
          mdio_oe_q <= 1'b0;
          mdio_o_q  <= 1'b1;
          if (rd_q) rdata_q <= rsh_q;
        end else begin
          mdio_o_q  <= state_d == PRE ? 1'b1 : sh_d[31];
          mdio_oe_q <= oe_d;
        end
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign mdc     = mdc_q;
  assign mdio_o  = mdio_o_q;
  assign mdio_oe = mdio_oe_q;
endmodule
